// File: rtl/bs_mac_seq_if.sv
// Operand/result handshake bundle for the bit-serial MAC engine.
// The master side stages operand sets and drains results; the slave side is the engine.
interface bs_mac_seq_if #(
    parameter int A_MAN_WIDTH   = 11,
    parameter int ACC_EXP_WIDTH = 6,
    parameter int VEC_LENGTH    = 4,
    parameter int W_BITS        = 8,
    parameter int ACC_WIDTH     = 32
);
    localparam int PW = $clog2(W_BITS + 1);

    logic                                         clr;
    logic                                         in_valid;
    logic                                         in_ready;
    logic [VEC_LENGTH-1:0][A_MAN_WIDTH-1:0]       a_man;
    logic [VEC_LENGTH-1:0][W_BITS-1:0]            w_man;
    logic [VEC_LENGTH-1:0][ACC_EXP_WIDTH-1:0]     delta_exp;
    logic [VEC_LENGTH-1:0]                        y_sign;
    logic [PW-1:0]                                w_prec;
    logic                                         out_valid;
    logic                                         out_ready;
    logic signed [ACC_WIDTH-1:0]                  acc_out;
    logic                                         busy;

    modport master (
        output clr, in_valid, a_man, w_man, delta_exp, y_sign, w_prec, out_ready,
        input  in_ready, out_valid, acc_out, busy
    );

    modport slave (
        input  clr, in_valid, a_man, w_man, delta_exp, y_sign, w_prec, out_ready,
        output in_ready, out_valid, acc_out, busy
    );
endinterface

// File: rtl/bs_mac_seq.sv
// Bit-serial multiply-accumulate: per-lane aligned, bit-gated, signed terms reduced by an
// adder tree and shift-accumulated MSB-first over a runtime weight precision.
module bs_mac_seq #(
    parameter int A_MAN_WIDTH   = 11,
    parameter int ACC_EXP_WIDTH = 6,
    parameter int VEC_LENGTH    = 4,
    parameter int W_BITS        = 8,
    parameter int ACC_WIDTH     = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    bs_mac_seq_if.slave   bus
);
    localparam int SH_W   = A_MAN_WIDTH + 3;
    localparam int TERM_W = A_MAN_WIDTH + 4;
    localparam int LVL    = $clog2(VEC_LENGTH);
    localparam int SUM_W  = TERM_W + LVL;
    localparam int PW     = $clog2(W_BITS + 1);
    localparam int CW     = (W_BITS > 1) ? $clog2(W_BITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                                   state_reg;
    logic [CW-1:0]                            cnt_reg;
    logic [ACC_WIDTH-1:0]                     acc_reg;
    logic [ACC_WIDTH-1:0]                     acc_out_reg;
    logic [VEC_LENGTH-1:0][A_MAN_WIDTH-1:0]   a_reg;
    logic [VEC_LENGTH-1:0][W_BITS-1:0]        w_reg;
    logic [VEC_LENGTH-1:0][ACC_EXP_WIDTH-1:0] delta_reg;
    logic [VEC_LENGTH-1:0]                    sign_reg;
    logic                                     in_ready_reg;
    logic                                     out_valid_reg;
    logic                                     busy_reg;

    logic [PW-1:0]                            p_eff;
    logic                                     accept;
    logic signed [SUM_W-1:0]                  lane_sum;
    logic [ACC_WIDTH-1:0]                     acc_next;

    always_comb begin
        p_eff = bus.w_prec;
        if (bus.w_prec == '0 || bus.w_prec > PW'(W_BITS))
            p_eff = PW'(W_BITS);
    end

    // DONE can hand straight over to a new operand set when the result is taken.
    assign accept = bus.in_valid &&
                    (state_reg == IDLE || (state_reg == DONE && bus.out_ready));

    generate
        for (genvar gi = 0; gi < VEC_LENGTH; gi++) begin : g_lane
            logic [A_MAN_WIDTH-1:0]   m;
            logic [SH_W-1:0]          al;
            logic signed [TERM_W-1:0] t;
            always_comb begin
                m = a_reg[gi] & {A_MAN_WIDTH{w_reg[gi][cnt_reg]}};
                if (32'(delta_reg[gi]) >= SH_W)
                    al = '0;
                else
                    al = {m, 3'b000} >> delta_reg[gi];
                t = sign_reg[gi] ? -$signed({1'b0, al}) : $signed({1'b0, al});
            end
        end

        // Balanced reduction; each level widens by one bit so no partial sum can overflow.
        for (genvar gl = 0; gl <= LVL; gl++) begin : g_lvl
            for (genvar gi = 0; gi < (VEC_LENGTH >> gl); gi++) begin : g_node
                logic signed [TERM_W+gl-1:0] s;
                if (gl == 0) begin : g_leaf
                    assign s = g_lane[gi].t;
                end else begin : g_add
                    assign s = $signed({g_lvl[gl-1].g_node[2*gi].s[TERM_W+gl-2],
                                        g_lvl[gl-1].g_node[2*gi].s})
                             + $signed({g_lvl[gl-1].g_node[2*gi+1].s[TERM_W+gl-2],
                                        g_lvl[gl-1].g_node[2*gi+1].s});
                end
            end
        end
    endgenerate

    assign lane_sum = g_lvl[LVL].g_node[0].s;
    assign acc_next = (acc_reg << 1) + {{(ACC_WIDTH-SUM_W){lane_sum[SUM_W-1]}}, lane_sum};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            acc_out_reg   <= '0;
            a_reg         <= '0;
            w_reg         <= '0;
            delta_reg     <= '0;
            sign_reg      <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (bus.clr) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (accept) begin
            state_reg     <= RUN;
            a_reg         <= bus.a_man;
            w_reg         <= bus.w_man;
            delta_reg     <= bus.delta_exp;
            sign_reg      <= bus.y_sign;
            acc_reg       <= '0;
            cnt_reg       <= CW'(p_eff - PW'(1));
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b1;
        end else begin
            case (state_reg)
                RUN: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        state_reg     <= DONE;
                        acc_out_reg   <= acc_next;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg || (state_reg == DONE && bus.out_ready);
    assign bus.out_valid = out_valid_reg;
    assign bus.acc_out   = acc_out_reg;
    assign bus.busy      = busy_reg;
endmodule
